gb_oam_dma: RTL and testbench

- Parametrised OAM DMA engine for the Game Boy system, replacing the `dma_active = 0` stub.
- A write to the DMA register starts a transfer. The engine copies LENGTH bytes from page {src,8'h00} into OAM at offsets 0..LENGTH-1, one byte per slot.
- During the transfer the engine owns the DMA read port (adr_rd/rd) and the OAM write port (adr_wr/wr), and asserts active so the system muxes the CPU off OAM and the source bus.

---
 rtl/gb_oam_dma_if.sv | 34 +++
 rtl/gb_oam_dma.sv | 141 ++++++++++++++
 tb/tb_gb_oam_dma.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/gb_oam_dma_if.sv
// +--------------------------------------------------------------------------+
// | gb_oam_dma_if -- CPU register port plus DMA source/OAM bus for gb_oam_dma |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

interface gb_oam_dma_if;
  logic [7:0]  adr;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        read_reg;
  logic        write_reg;
  logic [15:0] adr_rd;
  logic        rd;
  logic [7:0]  data_rd;
  logic [7:0]  adr_wr;
  logic        wr;
  logic [7:0]  data_wr;
  logic        active;

  // System side: drives CPU strobes and the source read data.
  modport master (
    output adr, din, read_reg, write_reg, data_rd,
    input  dout, adr_rd, rd, adr_wr, wr, data_wr, active
  );

  // DMA engine side.
  modport slave (
    input  adr, din, read_reg, write_reg, data_rd,
    output dout, adr_rd, rd, adr_wr, wr, data_wr, active
  );
endinterface

`default_nettype wire

// File: rtl/gb_oam_dma.sv
// +--------------------------------------------------------------------------+
// | gb_oam_dma -- OAM DMA engine; optional stall input under GB_DMA_HOLD_EN   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module gb_oam_dma #(
  parameter int          LENGTH          = 160,
  parameter int          CYCLES_PER_BYTE = 4,
  parameter int          START_DELAY     = 4,
  parameter logic [7:0]  REG_ADR         = 8'h46
) (
  input  logic         clk,
  input  logic         reset,
`ifdef GB_DMA_HOLD_EN
  input  logic         hold,
`endif
  gb_oam_dma_if.slave  bus
);

  localparam int PW = (CYCLES_PER_BYTE > 2) ? $clog2(CYCLES_PER_BYTE) : 1;
  localparam int DW = (START_DELAY > 1) ? $clog2(START_DELAY + 1) : 1;

  localparam logic [PW-1:0] PH_LAST  = PW'(CYCLES_PER_BYTE - 1);
  localparam logic [PW-1:0] PH_CAP   = PW'(CYCLES_PER_BYTE - 2);
  localparam logic [DW-1:0] DLY_INIT = DW'(START_DELAY - 1);
  localparam logic [7:0]    IDX_LAST = 8'(LENGTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DELAY = 2'd1,
    S_XFER  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    src_q,   src_d;
  logic [DW-1:0] dly_q,   dly_d;
  logic [7:0]    index_q, index_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [7:0]    buf_q,   buf_d;

  logic          stall;
  logic          reg_hit_wr;
  logic          xfer;
  logic          run;
  logic [7:0]    page;

`ifdef GB_DMA_HOLD_EN
  assign stall = hold;
`else
  assign stall = 1'b0;
`endif

  assign reg_hit_wr = bus.write_reg && (bus.adr == REG_ADR);

  // Pages E0..FF are the echo mirror of C0..DF.
  assign page = (src_q >= 8'hE0) ? (src_q - 8'h20) : src_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      src_q   <= 8'hFF;
      dly_q   <= '0;
      index_q <= 8'h00;
      phase_q <= '0;
      buf_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dly_q   <= dly_d;
      index_q <= index_d;
      phase_q <= phase_d;
      buf_q   <= buf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dly_d   = dly_q;
    index_d = index_q;
    phase_d = phase_q;
    buf_d   = buf_q;

    case (state_q)
      S_IDLE: begin
      end
      S_DELAY: begin
        if (dly_q == '0) begin
          state_d = S_XFER;
          phase_d = '0;
        end else begin
          dly_d = dly_q - DW'(1);
        end
      end
      S_XFER: begin
        if (!stall) begin
          if (phase_q == PH_CAP) begin
            buf_d = bus.data_rd;
          end
          if (phase_q == PH_LAST) begin
            phase_d = '0;
            if (index_q == IDX_LAST) begin
              state_d = S_IDLE;
            end else begin
              index_d = index_q + 8'd1;
            end
          end else begin
            phase_d = phase_q + PW'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A register write always (re)starts, overriding any slot bookkeeping.
    if (reg_hit_wr) begin
      src_d   = bus.din;
      state_d = S_DELAY;
      dly_d   = DLY_INIT;
      index_d = 8'h00;
      phase_d = '0;
    end
  end

  assign xfer = (state_q == S_XFER);
  assign run  = xfer && !stall;

  assign bus.active  = (state_q != S_IDLE);
  assign bus.rd      = run && (phase_q != PH_LAST);
  assign bus.wr      = run && (phase_q == PH_LAST);
  assign bus.adr_rd  = xfer ? {page, index_q} : 16'h0000;
  assign bus.adr_wr  = bus.wr ? index_q : 8'h00;
  assign bus.data_wr = bus.wr ? buf_q : 8'h00;
  assign bus.dout    = (bus.read_reg && (bus.adr == REG_ADR)) ? src_q : 8'hFF;

endmodule

`default_nettype wire

// File: tb/tb_gb_oam_dma.sv
// +--------------------------------------------------------------------------+
// | tb_gb_oam_dma -- directed self-checking bench for gb_oam_dma              |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_gb_oam_dma;
  localparam logic [7:0] REG = 8'h46;

  logic clk;
  logic reset;
`ifdef GB_DMA_HOLD_EN
  logic hold;
`endif

  int checks;
  int failures;

  // Per-run observations gathered by observe().
  int          act_first, act_last, act_cnt;
  int          rd_first_c, post_rd_c;
  logic [15:0] rd_first_adr, post_rd_adr, snap_adr_rd;
  logic [7:0]  snap_adr_wr;
  logic        snap_rd, snap_wr;
  int          wr_cnt, wr_bad, wr_after, strobe_bad, hi_bad, hold_bad, idx20_cnt;

  gb_oam_dma_if bus ();

  // Source memory model: each byte holds the low byte of its own address.
  assign bus.data_rd = bus.adr_rd[7:0];

  gb_oam_dma dut (
    .clk   (clk),
    .reset (reset),
`ifdef GB_DMA_HOLD_EN
    .hold  (hold),
`endif
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle 0 writes sval to the register; action 1 = register write of tval,
  // action 2 = one-cycle reset, both in cycle trig_c.
  task automatic observe(input logic [7:0] sval, input int maxc, input int trig_c,
                         input int action, input logic [7:0] tval,
                         input int hold_c, input int hold_n, input logic [7:0] exp_hi);
    int exp_k;
    exp_k = 0;
    act_first = -1; act_last = -1; act_cnt = 0;
    rd_first_c = -1; post_rd_c = -1;
    rd_first_adr = 16'h0; post_rd_adr = 16'h0; snap_adr_rd = 16'h0;
    snap_adr_wr = 8'h0; snap_rd = 1'b0; snap_wr = 1'b0;
    wr_cnt = 0; wr_bad = 0; wr_after = 0; strobe_bad = 0;
    hi_bad = 0; hold_bad = 0; idx20_cnt = 0;
    for (int c = 0; c <= maxc; c++) begin
      @(negedge clk);
      bus.read_reg  = 1'b0;
      bus.adr       = REG;
      bus.write_reg = (c == 0) || (action == 1 && c == trig_c);
      bus.din       = (c == 0) ? sval : tval;
      reset         = (action == 2 && c == trig_c);
`ifdef GB_DMA_HOLD_EN
      hold          = (c >= hold_c && c < hold_c + hold_n);
`endif
      #1;
      if (bus.active) begin
        if (act_first < 0) act_first = c;
        act_last = c;
        act_cnt++;
      end
      if (bus.rd && bus.wr) strobe_bad++;
      if ((bus.rd || bus.wr) && !bus.active) strobe_bad++;
      if (bus.rd && rd_first_c < 0) begin
        rd_first_c   = c;
        rd_first_adr = bus.adr_rd;
      end
      if (bus.rd && bus.adr_rd[15:8] != exp_hi && (action != 1 || c <= trig_c)) hi_bad++;
      if (c >= hold_c && c < hold_c + hold_n && (bus.rd || bus.wr)) hold_bad++;
      if (bus.wr) begin
        wr_cnt++;
        if (bus.adr_wr != exp_k[7:0] || bus.data_wr != exp_k[7:0]) wr_bad++;
        if (bus.adr_wr == 8'd20) idx20_cnt++;
        if (trig_c >= 0 && c > trig_c) wr_after++;
        exp_k++;
      end
      if (trig_c >= 0 && c > trig_c && bus.rd && post_rd_c < 0) begin
        post_rd_c   = c;
        post_rd_adr = bus.adr_rd;
      end
      if (c == trig_c) begin
        snap_rd     = bus.rd;
        snap_wr     = bus.wr;
        snap_adr_rd = bus.adr_rd;
        snap_adr_wr = bus.adr_wr;
        if (action == 1) exp_k = 0;
      end
    end
    @(negedge clk);
    bus.write_reg = 1'b0;
    reset         = 1'b0;
`ifdef GB_DMA_HOLD_EN
    hold          = 1'b0;
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    bus.adr = REG; bus.read_reg = 1'b1;
    #1;
    checks++; if (bus.dout !== 8'hFF) begin failures++; $display("FAIL reset_dout got=%0h exp=ff", bus.dout); end
    checks++; if (bus.active !== 1'b0) begin failures++; $display("FAIL reset_active got=%0b exp=0", bus.active); end
    checks++; if (bus.rd !== 1'b0) begin failures++; $display("FAIL reset_rd got=%0b exp=0", bus.rd); end
    checks++; if (bus.wr !== 1'b0) begin failures++; $display("FAIL reset_wr got=%0b exp=0", bus.wr); end
    checks++; if (bus.adr_rd !== 16'h0000) begin failures++; $display("FAIL reset_adr_rd got=%0h exp=0", bus.adr_rd); end
    checks++; if (bus.adr_wr !== 8'h00 || bus.data_wr !== 8'h00) begin failures++; $display("FAIL reset_wrbus got=%0h/%0h exp=0/0", bus.adr_wr, bus.data_wr); end
    bus.read_reg = 1'b0;
  endtask

  task automatic test_basic();
    observe(8'hC1, 700, -1, 0, 8'h00, -1, 0, 8'hC1);
    checks++; if (act_first !== 1) begin failures++; $display("FAIL basic_act_first got=%0d exp=1", act_first); end
    checks++; if (act_last !== 644) begin failures++; $display("FAIL basic_act_last got=%0d exp=644", act_last); end
    checks++; if (act_cnt !== 644) begin failures++; $display("FAIL basic_act_cnt got=%0d exp=644", act_cnt); end
    checks++; if (rd_first_c !== 5) begin failures++; $display("FAIL basic_first_rd_cyc got=%0d exp=5", rd_first_c); end
    checks++; if (rd_first_adr !== 16'hC100) begin failures++; $display("FAIL basic_first_rd_adr got=%0h exp=c100", rd_first_adr); end
    checks++; if (wr_cnt !== 160) begin failures++; $display("FAIL basic_wr_cnt got=%0d exp=160", wr_cnt); end
    checks++; if (wr_bad !== 0) begin failures++; $display("FAIL basic_wr_data got=%0d bad exp=0", wr_bad); end
    checks++; if (strobe_bad !== 0) begin failures++; $display("FAIL basic_strobes got=%0d bad exp=0", strobe_bad); end
    checks++; if (hi_bad !== 0) begin failures++; $display("FAIL basic_page got=%0d bad exp=0", hi_bad); end
  endtask

  task automatic test_readback(input logic [7:0] exp, input string name);
    @(negedge clk);
    bus.adr = REG; bus.read_reg = 1'b1;
    #1;
    checks++; if (bus.dout !== exp) begin failures++; $display("FAIL %s got=%0h exp=%0h", name, bus.dout, exp); end
    bus.adr = 8'h47;
    #1;
    checks++; if (bus.dout !== 8'hFF) begin failures++; $display("FAIL %s_other_adr got=%0h exp=ff", name, bus.dout); end
    bus.adr = REG; bus.read_reg = 1'b0;
    #1;
    checks++; if (bus.dout !== 8'hFF) begin failures++; $display("FAIL %s_no_strobe got=%0h exp=ff", name, bus.dout); end
  endtask

  task automatic test_echo();
    observe(8'hE3, 700, -1, 0, 8'h00, -1, 0, 8'hC3);
    checks++; if (rd_first_adr !== 16'hC300) begin failures++; $display("FAIL echo_first_adr got=%0h exp=c300", rd_first_adr); end
    checks++; if (hi_bad !== 0) begin failures++; $display("FAIL echo_page got=%0d bad exp=0", hi_bad); end
    checks++; if (wr_cnt !== 160) begin failures++; $display("FAIL echo_wr_cnt got=%0d exp=160", wr_cnt); end
    checks++; if (act_last !== 644) begin failures++; $display("FAIL echo_act_last got=%0d exp=644", act_last); end
  endtask

  task automatic test_back_to_back();
    // Cycle 208 is the write phase of index 50 (5 + 50*4 + 3).
    observe(8'hC0, 900, 208, 1, 8'hD0, -1, 0, 8'hC0);
    checks++; if (snap_wr !== 1'b1 || snap_adr_wr !== 8'd50) begin failures++; $display("FAIL restart_trig_wr got=%0b/%0d exp=1/50", snap_wr, snap_adr_wr); end
    checks++; if (wr_cnt !== 211) begin failures++; $display("FAIL restart_wr_total got=%0d exp=211", wr_cnt); end
    checks++; if (wr_after !== 160) begin failures++; $display("FAIL restart_wr_after got=%0d exp=160", wr_after); end
    checks++; if (wr_bad !== 0) begin failures++; $display("FAIL restart_wr_data got=%0d bad exp=0", wr_bad); end
    checks++; if (post_rd_c !== 213 || post_rd_adr !== 16'hD000) begin failures++; $display("FAIL restart_first_rd got=%0d/%0h exp=213/d000", post_rd_c, post_rd_adr); end
    checks++; if (act_last !== 852) begin failures++; $display("FAIL restart_act_last got=%0d exp=852", act_last); end
    checks++; if (act_cnt !== 852) begin failures++; $display("FAIL restart_no_gap got=%0d exp=852", act_cnt); end
    checks++; if (strobe_bad !== 0) begin failures++; $display("FAIL restart_strobes got=%0d bad exp=0", strobe_bad); end
  endtask

  task automatic test_mid_reset();
    // Cycle 46 is phase 1 of index 10 (5 + 10*4 + 1).
    observe(8'hC0, 80, 46, 2, 8'h00, -1, 0, 8'hC0);
    checks++; if (snap_rd !== 1'b1 || snap_adr_rd !== 16'hC00A) begin failures++; $display("FAIL mreset_trig_rd got=%0b/%0h exp=1/c00a", snap_rd, snap_adr_rd); end
    checks++; if (act_last !== 46) begin failures++; $display("FAIL mreset_act_last got=%0d exp=46", act_last); end
    checks++; if (wr_cnt !== 10) begin failures++; $display("FAIL mreset_wr_cnt got=%0d exp=10", wr_cnt); end
    checks++; if (wr_after !== 0) begin failures++; $display("FAIL mreset_wr_after got=%0d exp=0", wr_after); end
    checks++; if (bus.adr_rd !== 16'h0000) begin failures++; $display("FAIL mreset_adr_rd got=%0h exp=0", bus.adr_rd); end
  endtask

`ifdef GB_DMA_HOLD_EN
  task automatic test_hold();
    // Cycle 87 is phase 2 of index 20 (5 + 20*4 + 2).
    observe(8'hC1, 700, -1, 0, 8'h00, 87, 7, 8'hC1);
    checks++; if (hold_bad !== 0) begin failures++; $display("FAIL hold_strobes got=%0d bad exp=0", hold_bad); end
    checks++; if (idx20_cnt !== 1) begin failures++; $display("FAIL hold_idx20_writes got=%0d exp=1", idx20_cnt); end
    checks++; if (wr_bad !== 0) begin failures++; $display("FAIL hold_wr_data got=%0d bad exp=0", wr_bad); end
    checks++; if (wr_cnt !== 160) begin failures++; $display("FAIL hold_wr_cnt got=%0d exp=160", wr_cnt); end
    checks++; if (act_last !== 651) begin failures++; $display("FAIL hold_act_last got=%0d exp=651", act_last); end
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    bus.adr = 8'h00; bus.din = 8'h00;
    bus.read_reg = 1'b0; bus.write_reg = 1'b0;
`ifdef GB_DMA_HOLD_EN
    hold = 1'b0;
`endif
    test_reset();
    test_basic();
    test_readback(8'hC1, "readback_c1");
    test_echo();
    test_back_to_back();
    test_readback(8'hD0, "readback_d0");
    test_mid_reset();
    test_readback(8'hFF, "readback_after_reset");
`ifdef GB_DMA_HOLD_EN
    test_hold();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
